// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Predicts the next fetch PC combinationally and learns from resolved branches in MEM.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_npc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        inval,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX     = CTR_W'((1 << CTR_W) - 1);
  localparam logic [CTR_W-1:0] CTR_MIN     = '0;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_we;
  logic [CTR_W-1:0] ent_ctr;
  logic [CTR_W-1:0] ctr_nxt;
  logic [31:0]      target_nxt;

  // Word-alignment bits never participate in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign look_idx = lookup_pc[IDX_W+1:2];
  assign look_tag = lookup_pc[31:IDX_W+2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign upd_tag  = upd_pc[31:IDX_W+2];

  // Fetch-side prediction straight from registered state, no bypass of a same-cycle update.
  always_comb begin
    pred_hit   = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    pred_taken = pred_hit && ctr_q[look_idx][CTR_W-1];
    pred_npc   = pred_taken ? target_q[look_idx] : (lookup_pc + 32'd4);
  end

  // Next entry contents for the update port; a miss only writes when it allocates.
  always_comb begin
    upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    ent_ctr    = ctr_q[upd_idx];
    upd_we     = upd_valid && (upd_hit || upd_taken);
    ctr_nxt    = CTR_WEAK_T;
    target_nxt = upd_taken ? upd_target : target_q[upd_idx];
    if (upd_hit) begin
      if (upd_taken) begin
        ctr_nxt = (ent_ctr == CTR_MAX) ? ent_ctr : (ent_ctr + CTR_W'(1));
      end else begin
        ctr_nxt = (ent_ctr == CTR_MIN) ? ent_ctr : (ent_ctr - CTR_W'(1));
      end
    end
  end

  // Entry storage: reset beats invalidate, which beats the update write.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[IDX_W'(i)]  <= 1'b0;
        tag_q[IDX_W'(i)]    <= '0;
        target_q[IDX_W'(i)] <= '0;
        ctr_q[IDX_W'(i)]    <= CTR_WEAK_NT;
      end
    end else if (inval) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[IDX_W'(i)] <= 1'b0;
        ctr_q[IDX_W'(i)]   <= CTR_WEAK_NT;
      end
    end else if (upd_we) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= target_nxt;
      ctr_q[upd_idx]    <= ctr_nxt;
    end
  end

  // Statistics survive invalidation and wrap naturally.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lookup_en && pred_hit) begin
        stat_hits <= stat_hits + 32'd1;
      end
      if (upd_valid && upd_mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer (BTB) with per-entry saturating direction counters, parametrised in depth and counter width. It sits in the IF stage of the pipelined datapath. Every cycle it maps the fetch PC to a predicted next PC, so taken branches and jumps no longer cost a flush when they resolve in MEM. The MEM stage writes resolved outcomes back through a single update port.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- CTR_W, 2, direction counter width; 1..4
- TAG_W, 30-IDX_W, derived; tag = pc[31:IDX_W+2]
- CLK  in  1  clock; all state updates on posedge
- nRST  in  1  reset, synchronous, active-low
- lookup_en  in  1  fetch is valid this cycle (ihit & pc enable); gates stats only
- lookup_pc  in  32  current fetch PC (cpc)
- pred_hit  out  1  valid entry with matching tag at lookup_pc's index
- pred_taken  out  1  pred_hit & ctr[CTR_W-1]
- pred_npc  out  32  pred_taken ? entry target : lookup_pc+4
- upd_valid  in  1  resolved branch/jump in MEM, pipeline advancing
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual outcome (jumps always 1)
- upd_target  in  32  actual target (baddr/jaddr/rdat1)
- upd_mispredict  in  1  resolved npc ≠ npc predicted at fetch
- inval  in  1  invalidate all entries (halt / context flush)
- stat_hits  out  32  count of lookup_en cycles with pred_hit
- stat_mispredicts  out  32  count of upd_valid & upd_mispredict cycles

## Operation
- Index = pc[IDX_W+1:2]; pc[1:0] ignored. Entry = {valid, tag[TAG_W], target[32], ctr[CTR_W]}.
- Lookup is purely combinational from registered state; no added fetch latency.
- Update on posedge when upd_valid=1 and no reset/inval:
  - Tag hit: ctr saturating +1 if upd_taken, -1 if not; target←upd_target if upd_taken.
  - Miss and upd_taken: allocate (overwrite): valid←1, tag, target, ctr←2^(CTR_W-1) (weakly taken).
  - Miss and not taken: no change.
- Saturation: ctr never wraps; max 2^CTR_W-1, min 0.
- inval=1: all valid←0, counters←2^(CTR_W-1)-1. Any same-cycle update is discarded. Stat counters are not cleared.
- Stat counters wrap modulo 2^32.
- Reset (nRST=0 at posedge): all valid←0, ctr←2^(CTR_W-1)-1, target←0, tag←0, both stats←0. Reset has priority over inval and update.
- Reset outputs: pred_hit=0, pred_taken=0, pred_npc=lookup_pc+4, stat_hits=0, stat_mispredicts=0.
- Reset mid-operation: an in-flight update is dropped. No partial entry write is ever visible.

## Timing
- Lookup to prediction: 0 cycles (same cycle, combinational).
- Update to visible at lookup: 1 cycle (from the posedge after upd_valid).
- Same-cycle lookup and update to the same index: lookup sees pre-update contents (no bypass).
- No handshake on the update port; the caller asserts upd_valid for exactly one cycle per resolved instruction. A repeat across a stall counts twice.
- The caller must not hold upd_valid high during stalls.
- Stats increment at the posedge of the qualifying cycle and are visible the next cycle.
- Aliasing: two PCs with equal index but different tag evict each other. Equal index and equal tag share an entry.

## Test plan
- Reset then lookup_pc=0x40 -> pred_hit=0, pred_npc=0x44. Both stats read 0.
- Update pc=0x40, taken, target=0x100; next cycle lookup 0x40 -> pred_hit=1, pred_taken=1, pred_npc=0x100. Then two not-taken updates (CTR_W=2) -> pred_taken=0, pred_npc=0x44.
- Four taken updates to 0x40 then one not-taken -> ctr saturates at 3, then drops to 2, so still taken. An not-taken update at a miss (0x80) -> pred_hit stays 0.
- ENTRIES=16: allocate 0x40 (target 0x100), then allocate 0x80 (same index, target 0x200) -> lookup 0x40 misses, lookup 0x80 -> pred_npc=0x200.
- Same-cycle lookup+allocate at 0x40 -> that cycle pred_hit=0, next cycle pred_hit=1. inval with simultaneous update -> next cycle pred_hit=0 for all PCs.
- 5 cycles lookup_en with hits and 3 upd_mispredict pulses, then nRST low one cycle -> stats read 5/3 before reset and 0/0 after.
